// File: rtl/sweep_pkg.sv
// Shared state encoding and CRC-16-CCITT helper for the truth_table_sweeper.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } sweep_state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One byte of CRC-16-CCITT, data consumed MSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[15] ^ data[7 - i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ CRC16_POLY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/sweep_crc16.sv
// Byte-serial CRC-16-CCITT update stage used for the sweep response signature.
module sweep_crc16
    import sweep_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    always_comb begin
        crc_o = crc16_byte(crc_i, data_i);
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive-stimulus engine: walks every N_IN-bit vector, checks responses against EXPECT.
// Optional response signature enabled by defining SWEEP_SIGNATURE_EN.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int                           N_IN   = 3,
    parameter int                           N_OUT  = 1,
    parameter int                           DWELL  = 20,
    parameter logic [N_OUT*(2**N_IN)-1:0]   EXPECT = 8'b1110_1000,
    parameter int                           ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [N_OUT-1:0]  resp,
    output logic [N_IN-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [15:0]       sig
);

    localparam int             DWELL_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

    sweep_state_e        state_q, state_d;
    logic [N_IN-1:0]     stim_q, stim_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [15:0]         sig_q, sig_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [N_OUT-1:0]    exp_resp;
    logic [15:0]         crc_next;

`ifdef SWEEP_SIGNATURE_EN
    localparam logic [15:0] SIG_INIT = CRC16_INIT;

    sweep_crc16 u_crc (
        .crc_i  (sig_q),
        .data_i (8'(resp)),
        .crc_o  (crc_next)
    );
`else
    // Signature held at zero; the register folds to a constant.
    localparam logic [15:0] SIG_INIT = '0;

    always_comb begin
        crc_next = '0;
    end
`endif

    always_comb begin
        exp_resp = EXPECT[32'(stim_q) * N_OUT +: N_OUT];
    end

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        dwell_d = dwell_q;
        err_d   = err_q;
        sig_d   = sig_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;

        if (abort) begin
            state_d = IDLE;
            stim_d  = '0;
            dwell_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = DRIVE;
                        stim_d  = '0;
                        dwell_d = '0;
                        err_d   = '0;
                        sig_d   = SIG_INIT;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                    end
                end
                DRIVE: begin
                    if (dwell_q == DWELL_LAST) begin
                        if ((resp != exp_resp) && (err_q != '1)) begin
                            err_d = err_q + 1'b1;
                        end
                        sig_d   = crc_next;
                        dwell_d = '0;
                        if (stim_q == '1) begin
                            state_d = DONE;
                            stim_d  = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (err_d == '0);
                        end else begin
                            stim_d = stim_q + 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stim_q  <= '0;
            dwell_q <= '0;
            err_q   <= '0;
            sig_q   <= SIG_INIT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            dwell_q <= dwell_d;
            err_q   <= err_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign stim    = stim_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;
    assign sig     = sig_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper; sig expectations follow SWEEP_SIGNATURE_EN.
module tb_truth_table_sweeper;

    localparam logic [7:0]  MAJ   = 8'b1110_1000;
    localparam logic [31:0] EXP_C = 32'h9C3A_57E1;
`ifdef SWEEP_SIGNATURE_EN
    localparam bit SIG_EN = 1'b1;
`else
    localparam bit SIG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start_a = 1'b0, abort_a = 1'b0;
    logic start_b = 1'b0, abort_b = 1'b0;
    logic start_c = 1'b0, abort_c = 1'b0;

    logic [7:0] rtab [16];
    logic [7:0] etab [16];

    logic [2:0]  stim_a;  logic [0:0] resp_a;  logic [7:0] err_a;  logic [15:0] sig_a;
    logic [2:0]  stim_b;  logic [0:0] resp_b;  logic [1:0] err_b;  logic [15:0] sig_b;
    logic [3:0]  stim_c;  logic [1:0] resp_c;  logic [7:0] err_c;  logic [15:0] sig_c;
    logic busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;

    assign resp_a = rtab[{1'b0, stim_a}][0:0];
    assign resp_b = rtab[{1'b0, stim_b}][0:0];
    assign resp_c = rtab[stim_c][1:0];

    truth_table_sweeper u_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .resp(resp_a),
        .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .sig(sig_a)
    );

    truth_table_sweeper #(.N_IN(3), .N_OUT(1), .DWELL(3), .EXPECT(MAJ), .ERR_W(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .resp(resp_b),
        .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .sig(sig_b)
    );

    truth_table_sweeper #(.N_IN(4), .N_OUT(2), .DWELL(1), .EXPECT(EXP_C), .ERR_W(8)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .resp(resp_c),
        .stim(stim_c), .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c), .sig(sig_c)
    );

    int sel = 0;
    logic [31:0] o_stim, o_err;
    logic [15:0] o_sig;
    logic        o_busy, o_done, o_pass;

    always_comb begin
        case (sel)
            1: begin
                o_stim = 32'(stim_b); o_err = 32'(err_b); o_sig = sig_b;
                o_busy = busy_b; o_done = done_b; o_pass = pass_b;
            end
            2: begin
                o_stim = 32'(stim_c); o_err = 32'(err_c); o_sig = sig_c;
                o_busy = busy_c; o_done = done_c; o_pass = pass_c;
            end
            default: begin
                o_stim = 32'(stim_a); o_err = 32'(err_a); o_sig = sig_a;
                o_busy = busy_a; o_done = done_a; o_pass = pass_a;
            end
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v, input int k);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s unit=%0d k=%0d observed=%0h expected=%0h", tag, sel, k, obs, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input int s, input logic v);
        case (s)
            1: start_b = v;
            2: start_c = v;
            default: start_a = v;
        endcase
    endtask

    task automatic drive_abort(input int s, input logic v);
        case (s)
            1: abort_b = v;
            2: abort_c = v;
            default: abort_a = v;
        endcase
    endtask

    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    // mode: 0 golden, 1 vector 5 inverted, 2 stuck-at-0, 3 random flips, 4 all inverted
    task automatic load(input int s, input int mode);
        logic [31:0] ec;
        logic [7:0]  maj;
        logic [7:0]  msk;
        logic [7:0]  flip;
        ec  = EXP_C;
        maj = MAJ;
        msk = (s == 2) ? 8'h03 : 8'h01;
        for (int v = 0; v < 16; v++) begin
            etab[v] = (s == 2) ? 8'((ec >> (2 * v)) & 32'h3) : 8'((maj >> v) & 8'h01);
            case (mode)
                1: flip = (v == 5) ? msk : 8'h00;
                3: flip = 8'($urandom) & msk;
                4: flip = msk;
                default: flip = 8'h00;
            endcase
            rtab[v] = (mode == 2) ? 8'h00 : (etab[v] ^ flip);
        end
    endtask

    task automatic sweep(input int s, input int abort_at, input int start_at);
        int nv, dw, emax, mism, v;
        logic [15:0] crc;
        nv   = (s == 2) ? 16 : 8;
        dw   = (s == 0) ? 20 : ((s == 1) ? 3 : 1);
        emax = (s == 1) ? 3 : 255;
        sel  = s;
        mism = 0;
        crc  = 16'hFFFF;
        drive_start(s, 1'b1);
        cyc(1);
        drive_start(s, 1'b0);
        chk("pass_drop", 32'(o_pass), 32'd0, 0);
        for (int k = 0; k <= nv * dw; k++) begin
            if (k > 0 && (k % dw) == 0) begin
                v = k / dw - 1;
                if (rtab[v] != etab[v]) mism++;
                crc = crc_ref(crc, rtab[v]);
            end
            chk("stim", o_stim, (k < nv * dw) ? 32'(k / dw) : 32'd0, k);
            chk("busy", 32'(o_busy), 32'(k < nv * dw), k);
            chk("done", 32'(o_done), 32'(k >= nv * dw), k);
            chk("err_cnt", o_err, 32'((mism > emax) ? emax : mism), k);
            chk("sig", 32'(o_sig), SIG_EN ? 32'(crc) : 32'd0, k);
            if (k == nv * dw) begin
                chk("pass", 32'(o_pass), 32'(mism == 0), k);
            end else begin
                drive_start(s, k == start_at);
                if (k == abort_at) begin
                    drive_abort(s, 1'b1);
                    cyc(1);
                    drive_abort(s, 1'b0);
                    drive_start(s, 1'b0);
                    chk("abort_stim", o_stim, 32'd0, k + 1);
                    chk("abort_busy", 32'(o_busy), 32'd0, k + 1);
                    chk("abort_done", 32'(o_done), 32'd0, k + 1);
                    chk("abort_err", o_err, 32'((mism > emax) ? emax : mism), k + 1);
                    chk("abort_sig", 32'(o_sig), SIG_EN ? 32'(crc) : 32'd0, k + 1);
                    cyc(2);
                    chk("idle_stim", o_stim, 32'd0, k + 3);
                    chk("idle_busy", 32'(o_busy), 32'd0, k + 3);
                    return;
                end
                cyc(1);
                drive_start(s, 1'b0);
            end
        end
    endtask

    task automatic chk_reset(input int s);
        sel = s;
        #0;
        chk("rst_stim", o_stim, 32'd0, -1);
        chk("rst_busy", 32'(o_busy), 32'd0, -1);
        chk("rst_done", 32'(o_done), 32'd0, -1);
        chk("rst_pass", 32'(o_pass), 32'd0, -1);
        chk("rst_err", o_err, 32'd0, -1);
        chk("rst_sig", 32'(o_sig), SIG_EN ? 32'h0000_FFFF : 32'd0, -1);
    endtask

    initial begin
        load(0, 0);
        cyc(3);
        chk_reset(0);
        chk_reset(1);
        chk_reset(2);
        rst = 1'b0;
        cyc(2);

        load(0, 0); sweep(0, -1, -1);
        load(0, 1); sweep(0, -1, -1);
        repeat (3) begin
            load(0, 3); sweep(0, -1, -1);
        end
        load(0, 4); sweep(0, 50, -1);
        load(0, 0); sweep(0, -1, -1);

        load(1, 2); sweep(1, -1, -1);
        repeat (3) begin
            load(1, 3); sweep(1, -1, -1);
        end

        load(2, 4); sweep(2, -1, 5);
        repeat (3) begin
            load(2, 3); sweep(2, -1, -1);
        end

        // Reset in the middle of a sweep with one mismatch already counted.
        load(0, 4);
        sel = 0;
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
        cyc(30);
        chk("mid_err", o_err, 32'd1, 30);
        chk("mid_stim", o_stim, 32'd1, 30);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk_reset(0);
        cyc(3);
        chk_reset(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Parametrised, synthesizable exhaustive-stimulus engine for small combinational blocks. Drives every input combination of an N_IN-bit DUT in ascending binary order, holds each vector for DWELL cycles, and samples the DUT response on the last cycle of each dwell. Compares each sample against a parameter truth table and reports a mismatch count and pass/fail. Sits beside the DUT in on-chip self-test and in benches, replacing hand-written per-vector stimulus lists.

Parameters:
N_IN, 3, DUT input width (1..16); sweep length 2**N_IN vectors
N_OUT, 1, DUT output width (1..8)
DWELL, 20, clock cycles each vector is held (>=1)
EXPECT, 8'b1110_1000, expected table: bits [v*N_OUT +: N_OUT] = expected response for vector v; width N_OUT*2**N_IN
ERR_W, 8, mismatch counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin sweep; sampled in IDLE or DONE only
abort  in  1  terminate sweep, return to IDLE
resp  in  N_OUT  DUT response
stim  out  N_IN  DUT stimulus vector
busy  out  1  high in DRIVE
done  out  1  high in DONE
pass  out  1  valid while done; 1 iff err_cnt==0
err_cnt  out  ERR_W  saturating mismatch count
sig  out  16  response signature (SIGNATURE_EN only, else tied 0)

Behaviour:
- One clock; reset is synchronous and active-high. Reset values: stim=0, busy=0, done=0, pass=0, err_cnt=0, sig=16'hFFFF; state=IDLE.
- States: IDLE, DRIVE, DONE. Outputs registered.
- IDLE: start=1 -> DRIVE next cycle; stim=0, dwell_cnt=0, err_cnt=0, sig=16'hFFFF.
- DRIVE: dwell_cnt increments each cycle. When dwell_cnt==DWELL-1: sample resp; if resp != EXPECT[stim*N_OUT +: N_OUT], err_cnt+1 (saturate at all-ones). Same cycle: if stim==2**N_IN-1 -> DONE and stim=0; else stim+1, dwell_cnt=0.
- Latency: stim changes on clock edge after sample; total DRIVE time = DWELL*2**N_IN cycles; done asserts the following cycle.
- DONE: done=1 held; pass=(err_cnt==0). start=1 -> restart as from IDLE (counters cleared). done/pass drop in the same edge.
- start while DRIVE ignored. abort has priority over start and over sampling: any state -> IDLE, stim=0, busy=0, done=0; err_cnt and sig retained for debug.
- DWELL=1: one cycle per vector, sample every cycle.
- rst mid-sweep: all outputs to reset values on the next edge.
- dwell_cnt width = clog2(DWELL) min 1; stim wraps via explicit compare, never arithmetic overflow.

Optional Feature:
SWEEP_SIGNATURE_EN. Defined: sig is a CRC-16-CCITT (poly 0x1021, init 0xFFFF) updated with resp (zero-extended to 8 bits, MSB first) at each sample point; final value stable in DONE. Undefined: CRC logic removed, sig constant 0.

Decomposition:
Package sweep_pkg: state enum (IDLE/DRIVE/DONE), CRC16_POLY=16'h1021, CRC16_INIT=16'hFFFF, crc16_byte function. One sub-module natural: sweep_crc16 (byte-serial CRC update, instantiated only under SWEEP_SIGNATURE_EN).

Test Plan:
- Defaults, DUT = 3-input majority, start pulse -> stim 0..7 each held 20 cycles, done at cycle 161 after start, err_cnt=0, pass=1.
- Same, DUT output forced inverted for vector 5 only -> err_cnt=1, pass=0; EXPECT bit 5 comparison at stim=5 sample cycle.
- ERR_W=2, DUT output stuck-at-0 vs majority (4 ones expected) -> err_cnt saturates at 3, pass=0.
- abort at cycle 50 (stim=2) -> next cycle IDLE, stim=0, busy=0, err_cnt unchanged; new start -> full sweep from 0.
- DWELL=1, N_IN=4, start pulsed during DRIVE -> ignored; 16 vectors in 16 cycles, done at cycle 17; restart from DONE clears err_cnt.
- SWEEP_SIGNATURE_EN, majority DUT, responses 0,0,0,1,0,1,1,1 -> sig equals golden CRC-16-CCITT of those 8 bytes computed by bench model; rst mid-sweep -> sig=16'hFFFF.
